fetch_request_unit: RTL and testbench
=====================================

// Module: fetch_request_unit
// PURPOSE
// Owns the program counter and memory-request sequencing for the single-cycle core. Sits upstream
// of the control unit: drives imemaddr, whose returned imemload the control unit decodes. Consumes
// that decode (pc_select, jump_data, dREN/dWEN, cpu_halt) plus datapath flags to pick the next PC.
// Arbitrates the instruction fetch and the data access onto the cache port, and latches halt.
// PARAMETERS
// PC_INIT    32'h0000_0000   PC value loaded on reset
// PORTS
// CLK         in   1   core clock, rising edge
// nRST        in   1   asynchronous reset, active-high (asserted = 1)
// ihit        in   1   instruction cache hit; imemload valid this cycle
// dhit        in   1   data cache hit; current data access completes this cycle
// pc_select   in   3   pcsel_t from control unit: NEXT/JUMP/BRANCH_IF_EQUAL/BRANCH_IF_NOT_EQUAL/JUMPREGISTER/PC_HALT
// jump_data   in   32  control-unit jump word; bits [25:0] are the jump target
// immediate   in   32  sign-extended branch offset (word units)
// rdat1       in   32  register rs value, used for JR
// zero        in   1   ALU zero flag (rs - rt == 0)
// dREN_in     in   1   control unit requests a load (LW/LL)
// dWEN_in     in   1   control unit requests a store (SW/SC)
// cpu_halt_in in   1   control unit decoded HALT
// imemaddr    out  32  current PC; instruction fetch address
// imemREN     out  1   instruction read request
// dmemREN     out  1   data read request (registered)
// dmemWEN     out  1   data write request (registered)
// pc_plus4    out  32  PC + 4; return address for JAL
// halt        out  1   sticky halt flag
// BEHAVIOUR
// - Reset (nRST=1, async): PC<=PC_INIT, state<=FETCH, dmemREN=dmemWEN=halt=0; imemREN forced 0 while asserted.
// - FSM states: FETCH, DATA, HALTED. imemREN = (state==FETCH) & !nRST.
// - FETCH, ihit=0: hold PC, remain FETCH.
// - FETCH, ihit=1 & cpu_halt_in: halt<=1, PC unchanged, ->HALTED (halt wins over dREN/dWEN).
// - FETCH, ihit=1 & (dREN_in|dWEN_in): dmemREN<=dREN_in, dmemWEN<=dWEN_in, PC held, ->DATA.
// - FETCH, ihit=1 otherwise: PC<=next_pc, remain FETCH (one instruction per hit cycle).
// - DATA: PC held so imemload and decode stay stable; on dhit: dmemREN,dmemWEN<=0, PC<=next_pc, ->FETCH.
// - ihit in DATA and dhit in FETCH are ignored. dREN_in & dWEN_in both set: both latched (illegal decode, no check).
// - HALTED: terminal until reset; all requests 0, PC frozen, halt=1.
// - next_pc (32-bit, wraps modulo 2^32, no overflow flag):
//     NEXT                -> pc+4
//     JUMP                -> {pc_plus4[31:28], jump_data[25:0], 2'b00}
//     JUMPREGISTER        -> rdat1 (no alignment fixup)
//     BRANCH_IF_EQUAL     -> zero ? pc+4+(immediate<<2) : pc+4
//     BRANCH_IF_NOT_EQUAL -> !zero ? pc+4+(immediate<<2) : pc+4
//     PC_HALT / undefined -> pc
// - Latency: 1 cycle per instruction on ihit; loads/stores take >=2 (fetch hit + data hit).
// - Reset mid-DATA clears the outstanding request immediately; no write completes after reset.
// STRUCTURE
// - pcsel_t and fru_state_t (FETCH/DATA/HALTED) live in cpu_types_pkg.
// - One sub-module, npc_calc: purely combinational next_pc from pc, pc_select, jump_data, immediate, rdat1, zero.
// - Top level holds the PC register, FSM and registered dmem request flags.
// TESTING
// - Reset: PC_INIT=0; deassert nRST, ihit=1, pc_select=NEXT x3 -> imemaddr 0,4,8,C.
// - Branch: pc=0x10, BEQ, imm=0xFFFF_FFFE, zero=1 -> next imemaddr 0x0C; zero=0 -> 0x14.
// - Jump/JR: pc=0xF000_0000, JUMP, jump_data[25:0]=0x40 -> 0xF000_0100; JR, rdat1=0x200 -> 0x200.
// - Load stall: ihit with dREN_in=1 -> dmemREN=1 next cycle, PC held 3 cycles with dhit=0; dhit -> dmemREN=0, PC+4.
// - Halt: ihit & cpu_halt_in & dWEN_in -> halt=1, dmemWEN stays 0, imemREN=0, PC frozen for 10 cycles.
// - Async reset while in DATA with dmemWEN=1 -> dmemWEN=0 same cycle, PC=PC_INIT, FETCH after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the single-cycle core: PC-select codes from the control unit
// and the fetch/request sequencer states.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    NEXT                = 3'd0,
    JUMP                = 3'd1,
    BRANCH_IF_EQUAL     = 3'd2,
    BRANCH_IF_NOT_EQUAL = 3'd3,
    JUMPREGISTER        = 3'd4,
    PC_HALT             = 3'd5
  } pcsel_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } fru_state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, jump, jump-register and
// conditional branch targets, all modulo 2^32.
module npc_calc
  import cpu_types_pkg::*;
(
  input  logic [WORD_W-1:0] pc_i,
  input  logic [2:0]        pc_select_i,
  input  logic [WORD_W-1:0] jump_data_i,
  input  logic [WORD_W-1:0] immediate_i,
  input  logic [WORD_W-1:0] rdat1_i,
  input  logic              zero_i,
  output logic [WORD_W-1:0] pc_plus4_o,
  output logic [WORD_W-1:0] next_pc_o
);

  logic [WORD_W-1:0] branch_target;
  pcsel_t            sel;

  // Only the 26-bit target field of the jump word is meaningful here.
  logic unused_jump_bits;
  assign unused_jump_bits = ^jump_data_i[31:26];

  assign sel           = pcsel_t'(pc_select_i);
  assign pc_plus4_o    = pc_i + 32'd4;
  assign branch_target = pc_plus4_o + (immediate_i << 2);

  // NOTE: the default assignment ahead of the case keeps this block free of
  // inferred latches even for the unused pc_select encodings.
  always_comb begin
    next_pc_o = pc_i;
    case (sel)
      NEXT:                next_pc_o = pc_plus4_o;
      JUMP:                next_pc_o = {pc_plus4_o[31:28], jump_data_i[25:0], 2'b00};
      JUMPREGISTER:        next_pc_o = rdat1_i;
      BRANCH_IF_EQUAL:     next_pc_o = zero_i ? branch_target : pc_plus4_o;
      BRANCH_IF_NOT_EQUAL: next_pc_o = zero_i ? pc_plus4_o : branch_target;
      default:             next_pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_request_unit.sv
// Program counter owner and cache-port sequencer: one instruction per ihit,
// loads/stores hold the PC until dhit, HALT latches until reset.
module fetch_request_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [2:0]  pc_select,
  input  logic [31:0] jump_data,
  input  logic [31:0] immediate,
  input  logic [31:0] rdat1,
  input  logic        zero,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic        cpu_halt_in,
  output logic [31:0] imemaddr,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] pc_plus4,
  output logic        halt
);

  fru_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        dren_q, dren_d;
  logic        dwen_q, dwen_d;
  logic        halt_q, halt_d;
  logic [31:0] next_pc;

  npc_calc u_npc_calc (
    .pc_i        (pc_q),
    .pc_select_i (pc_select),
    .jump_data_i (jump_data),
    .immediate_i (immediate),
    .rdat1_i     (rdat1),
    .zero_i      (zero),
    .pc_plus4_o  (pc_plus4),
    .next_pc_o   (next_pc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset is asynchronous and active-high.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dren_q  <= dren_d;
      dwen_q  <= dwen_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dren_d  = dren_q;
    dwen_d  = dwen_q;
    halt_d  = halt_q;
    case (state_q)
      FETCH: begin
        if (ihit) begin
          if (cpu_halt_in) begin
            halt_d  = 1'b1;
            state_d = HALTED;
          end else if (dREN_in || dWEN_in) begin
            dren_d  = dREN_in;
            dwen_d  = dWEN_in;
            state_d = DATA;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      // PC stays put so imemload, and therefore the decode, is stable until dhit.
      DATA: begin
        if (dhit) begin
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      HALTED: begin
        dren_d = 1'b0;
        dwen_d = 1'b0;
        halt_d = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  assign imemaddr = pc_q;
  assign imemREN  = (state_q == FETCH) && !nRST;
  assign dmemREN  = dren_q;
  assign dmemWEN  = dwen_q;
  assign halt     = halt_q;

endmodule

// File: tb/tb_fetch_request_unit.sv
// Self-checking bench for fetch_request_unit: next-PC vector table, directed
// stall/halt/reset sequences, and a randomized run against a behavioural model.
module tb_fetch_request_unit;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, zero, dREN_in, dWEN_in, cpu_halt_in;
  logic [2:0]  pc_select;
  logic [31:0] jump_data, immediate, rdat1;
  logic [31:0] imemaddr, pc_plus4;
  logic        imemREN, dmemREN, dmemWEN, halt;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_request_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .dhit        (dhit),
    .pc_select   (pc_select),
    .jump_data   (jump_data),
    .immediate   (immediate),
    .rdat1       (rdat1),
    .zero        (zero),
    .dREN_in     (dREN_in),
    .dWEN_in     (dWEN_in),
    .cpu_halt_in (cpu_halt_in),
    .imemaddr    (imemaddr),
    .imemREN     (imemREN),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .pc_plus4    (pc_plus4),
    .halt        (halt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] start_pc;
    logic [2:0]  sel;
    logic [31:0] jd;
    logic [31:0] imm;
    logic [31:0] rd;
    logic        z;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ihit = 0; dhit = 0; zero = 0; dREN_in = 0; dWEN_in = 0; cpu_halt_in = 0;
    pc_select = NEXT; jump_data = 0; immediate = 0; rdat1 = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    nRST = 1;
    step();
    step();
    nRST = 0;
  endtask

  // Load an arbitrary PC through a jump-register instruction.
  task automatic set_pc(input logic [31:0] target);
    clear_inputs();
    ihit = 1; pc_select = JUMPREGISTER; rdat1 = target;
    step();
    clear_inputs();
  endtask

  // Reference next-PC computed directly from the architectural rules.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [2:0] sel,
                                           input logic [31:0] jd, input logic [31:0] imm,
                                           input logic [31:0] rd, input logic z);
    logic [31:0] seq, taken;
    seq   = pc + 32'd4;
    taken = seq + imm * 32'd4;
    case (sel)
      3'd0:    return seq;
      3'd1:    return (seq & 32'hF000_0000) | ((jd & 32'h03FF_FFFF) * 32'd4);
      3'd2:    return z ? taken : seq;
      3'd3:    return z ? seq : taken;
      3'd4:    return rd;
      default: return pc;
    endcase
  endfunction

  // Model state for the randomized run.
  logic [31:0] m_pc;
  bit          m_busy, m_halted, m_ren, m_wen;

  initial begin
    vecs[0]  = '{32'h0000_0010, 3'd2, 32'h0,         32'hFFFF_FFFE, 32'h0,   1'b1, 32'h0000_000C};
    vecs[1]  = '{32'h0000_0010, 3'd2, 32'h0,         32'hFFFF_FFFE, 32'h0,   1'b0, 32'h0000_0014};
    vecs[2]  = '{32'h0000_0010, 3'd3, 32'h0,         32'hFFFF_FFFE, 32'h0,   1'b0, 32'h0000_000C};
    vecs[3]  = '{32'h0000_0010, 3'd3, 32'h0,         32'hFFFF_FFFE, 32'h0,   1'b1, 32'h0000_0014};
    vecs[4]  = '{32'hF000_0000, 3'd1, 32'h0000_0040, 32'h0,         32'h0,   1'b0, 32'hF000_0100};
    vecs[5]  = '{32'hF000_0000, 3'd4, 32'h0,         32'h0,         32'h200, 1'b0, 32'h0000_0200};
    vecs[6]  = '{32'hFFFF_FFFC, 3'd0, 32'h0,         32'h0,         32'h0,   1'b0, 32'h0000_0000};
    vecs[7]  = '{32'h0000_0100, 3'd5, 32'h0,         32'h0,         32'h0,   1'b0, 32'h0000_0100};
    vecs[8]  = '{32'h0000_0100, 3'd7, 32'h0,         32'h0,         32'h0,   1'b1, 32'h0000_0100};
    vecs[9]  = '{32'h0000_0020, 3'd1, 32'hFFFF_FFFF, 32'h0,         32'h0,   1'b0, 32'h0FFF_FFFC};
    vecs[10] = '{32'h7FFF_FFF0, 3'd2, 32'h0,         32'h0000_0010, 32'h0,   1'b1, 32'h8000_0034};
    vecs[11] = '{32'h0000_0040, 3'd4, 32'h0,         32'h0,         32'h123, 1'b0, 32'h0000_0123};
    vecs[12] = '{32'hEFFF_FFFC, 3'd1, 32'h0000_0001, 32'h0,         32'h0,   1'b0, 32'hF000_0004};

    // Reset state, including ihit held high while reset is asserted.
    clear_inputs();
    nRST = 1;
    #1;
    ihit = 1;
    step();
    step();
    check("rst_pc", imemaddr, 32'h0);
    check("rst_imemREN", {31'b0, imemREN}, 32'h0);
    check("rst_dmemREN", {31'b0, dmemREN}, 32'h0);
    check("rst_dmemWEN", {31'b0, dmemWEN}, 32'h0);
    check("rst_halt", {31'b0, halt}, 32'h0);
    nRST = 0;
    #1;
    check("seq_pc0", imemaddr, 32'h0);
    check("seq_imemREN", {31'b0, imemREN}, 32'h1);
    step(); check("seq_pc4", imemaddr, 32'h4);
    step(); check("seq_pc8", imemaddr, 32'h8);
    step(); check("seq_pcC", imemaddr, 32'hC);

    // Table of next-PC rules.
    for (int i = 0; i < 13; i++) begin
      set_pc(vecs[i].start_pc);
      check($sformatf("vec%0d_start", i), imemaddr, vecs[i].start_pc);
      check($sformatf("vec%0d_plus4", i), pc_plus4, vecs[i].start_pc + 32'd4);
      ihit = 1; pc_select = vecs[i].sel; jump_data = vecs[i].jd;
      immediate = vecs[i].imm; rdat1 = vecs[i].rd; zero = vecs[i].z;
      step();
      check($sformatf("vec%0d_next", i), imemaddr, vecs[i].exp_pc);
      clear_inputs();
    end

    // ihit=0 holds PC; dhit in FETCH is ignored.
    set_pc(32'h40);
    dhit = 1; pc_select = NEXT;
    step(); step();
    check("nohit_hold", imemaddr, 32'h40);

    // Load stall: PC held while dhit=0, ihit in DATA ignored.
    clear_inputs();
    ihit = 1; dREN_in = 1; pc_select = NEXT;
    step();
    check("ld_dmemREN", {31'b0, dmemREN}, 32'h1);
    check("ld_imemREN", {31'b0, imemREN}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("ld_hold%0d", c), imemaddr, 32'h40);
      check($sformatf("ld_ren%0d", c), {31'b0, dmemREN}, 32'h1);
    end
    dhit = 1;
    step();
    check("ld_done_ren", {31'b0, dmemREN}, 32'h0);
    check("ld_done_pc", imemaddr, 32'h44);
    check("ld_done_imemREN", {31'b0, imemREN}, 32'h1);
    clear_inputs();

    // Asynchronous reset in the middle of a store.
    set_pc(32'h300);
    ihit = 1; dWEN_in = 1;
    step();
    check("st_dmemWEN", {31'b0, dmemWEN}, 32'h1);
    ihit = 0;
    #3;
    nRST = 1;
    #1;
    check("arst_dmemWEN", {31'b0, dmemWEN}, 32'h0);
    check("arst_pc", imemaddr, 32'h0);
    check("arst_imemREN", {31'b0, imemREN}, 32'h0);
    clear_inputs();
    @(posedge CLK); #1;
    nRST = 0;
    #1;
    check("arst_fetch", {31'b0, imemREN}, 32'h1);
    ihit = 1; pc_select = NEXT;
    step();
    check("arst_next", imemaddr, 32'h4);
    clear_inputs();

    // Randomized run against the behavioural model.
    apply_reset();
    m_pc = 32'h0; m_busy = 0; m_halted = 0; m_ren = 0; m_wen = 0;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] tgt;
      if (m_halted) begin
        apply_reset();
        m_pc = 32'h0; m_busy = 0; m_halted = 0; m_ren = 0; m_wen = 0;
      end
      ihit        = ($urandom_range(0, 3) != 0);
      dhit        = ($urandom_range(0, 1) != 0);
      pc_select   = 3'($urandom_range(0, 7));
      jump_data   = $urandom;
      immediate   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(8'($urandom)));
      rdat1       = $urandom;
      zero        = ($urandom_range(0, 1) != 0);
      dREN_in     = ($urandom_range(0, 3) == 0);
      dWEN_in     = ($urandom_range(0, 3) == 0);
      cpu_halt_in = ($urandom_range(0, 79) == 0);
      tgt = ref_next(m_pc, pc_select, jump_data, immediate, rdat1, zero);
      if (m_halted) begin
        // frozen
      end else if (m_busy) begin
        if (dhit) begin
          m_pc = tgt; m_busy = 0; m_ren = 0; m_wen = 0;
        end
      end else if (ihit) begin
        if (cpu_halt_in) m_halted = 1;
        else if (dREN_in || dWEN_in) begin
          m_busy = 1; m_ren = dREN_in; m_wen = dWEN_in;
        end else m_pc = tgt;
      end
      step();
      check("rnd_pc", imemaddr, m_pc);
      check("rnd_plus4", pc_plus4, m_pc + 32'd4);
      check("rnd_imemREN", {31'b0, imemREN}, {31'b0, !m_busy && !m_halted});
      check("rnd_dmemREN", {31'b0, dmemREN}, {31'b0, m_ren});
      check("rnd_dmemWEN", {31'b0, dmemWEN}, {31'b0, m_wen});
      check("rnd_halt", {31'b0, halt}, {31'b0, m_halted});
    end

    // Halt wins over a simultaneous store and freezes everything.
    apply_reset();
    set_pc(32'h80);
    ihit = 1; cpu_halt_in = 1; dWEN_in = 1;
    step();
    check("hlt_halt", {31'b0, halt}, 32'h1);
    check("hlt_dmemWEN", {31'b0, dmemWEN}, 32'h0);
    check("hlt_imemREN", {31'b0, imemREN}, 32'h0);
    check("hlt_pc", imemaddr, 32'h80);
    clear_inputs();
    for (int c = 0; c < 10; c++) begin
      ihit = 1; dhit = 1; pc_select = NEXT; dREN_in = c[0]; dWEN_in = c[1];
      step();
      check($sformatf("hlt_frozen%0d", c), imemaddr, 32'h80);
      check($sformatf("hlt_sticky%0d", c), {31'b0, halt}, 32'h1);
      check($sformatf("hlt_noreq%0d", c), {29'b0, imemREN, dmemREN, dmemWEN}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
